// File: rtl/integral_window_buffer_pkg.sv
// Shared definitions for the integral window buffer.
// Holds the FSM state encoding, a constant clog2 used to size counters and
// integral elements, and the element-index helper that fixes the layout of
// the packed integral output (element (r,c) at index r*n+c, r=0 top row).
package integral_window_buffer_pkg;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    COMPUTE = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) result = i + 1;
    return result;
  endfunction

  // Bits needed for one integral element: n*n*(2^p-1) is the largest sum.
  function automatic int integral_width(input int n, input int p);
    return clog2(n * n * ((1 << p) - 1) + 1);
  endfunction

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/integral_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for integral_window_buffer.
// Signals:
//   pixel_valid, pixel_data   producer -> block, raster-order pixels
//   pixel_ready               block -> producer
//   window_valid, window_x, window_y, integral_packed, frame_done
//                             block -> consumer
//   window_ready              consumer -> block
// Modports: master = producer/consumer side, slave = the block.
interface integral_window_buffer_if #(
  parameter int IMAGE_WIDTH  = 7,
  parameter int IMAGE_HEIGHT = 5,
  parameter int WINDOW_SIZE  = 4,
  parameter int PIXEL_WIDTH  = 1
);
  import integral_window_buffer_pkg::*;

  localparam int WD  = clog2(IMAGE_WIDTH + 1);
  localparam int HD  = clog2(IMAGE_HEIGHT + 1);
  localparam int WDI = integral_width(WINDOW_SIZE, PIXEL_WIDTH);

  logic                                     pixel_valid;
  logic                                     pixel_ready;
  logic [PIXEL_WIDTH-1:0]                   pixel_data;
  logic                                     window_valid;
  logic                                     window_ready;
  logic [WD-1:0]                            window_x;
  logic [HD-1:0]                            window_y;
  logic [WDI*WINDOW_SIZE*WINDOW_SIZE-1:0]   integral_packed;
  logic                                     frame_done;

  modport master (
    output pixel_valid, pixel_data, window_ready,
    input  pixel_ready, window_valid, window_x, window_y, integral_packed, frame_done
  );

  modport slave (
    input  pixel_valid, pixel_data, window_ready,
    output pixel_ready, window_valid, window_x, window_y, integral_packed, frame_done
  );

endinterface

// File: rtl/integral_window_buffer_line_store.sv
// Line store holding the last n image rows (one slot per row, slot = row mod n).
// Ports:
//   clk                      rising-edge clock
//   wr_en/wr_slot/wr_col/wr_data   single pixel write port
//   rd_slot/rd_col           row segment address: slot and leftmost column
//   seg                      registered n-pixel segment, pixel j at [j*P +: P]
// Contents are not reset; only the segment read during COMPUTE matters.
module integral_line_store
  import integral_window_buffer_pkg::*;
#(
  parameter int N           = 4,
  parameter int IMAGE_WIDTH = 7,
  parameter int PIXEL_WIDTH = 1,
  parameter int SW          = 2,
  parameter int WD          = 3
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [SW-1:0]            wr_slot,
  input  logic [WD-1:0]            wr_col,
  input  logic [PIXEL_WIDTH-1:0]   wr_data,
  input  logic [SW-1:0]            rd_slot,
  input  logic [WD-1:0]            rd_col,
  output logic [N*PIXEL_WIDTH-1:0] seg
);

  localparam int DEPTH = N * IMAGE_WIDTH * PIXEL_WIDTH;
  localparam int AW    = clog2(DEPTH);

  // Flat bit vector: pixel (slot, col) at bit offset (slot*IMAGE_WIDTH+col)*P.
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_base;

  assign wr_base = AW'((int'(wr_slot) * IMAGE_WIDTH + int'(wr_col)) * PIXEL_WIDTH);

  always_ff @(posedge clk)
    if (wr_en) mem[wr_base +: PIXEL_WIDTH] <= wr_data;

  for (genvar j = 0; j < N; j++) begin : g_read
    logic [AW-1:0] rd_base;
    assign rd_base = AW'((int'(rd_slot) * IMAGE_WIDTH + int'(rd_col) + j) * PIXEL_WIDTH);
    always_ff @(posedge clk)
      seg[j*PIXEL_WIDTH +: PIXEL_WIDTH] <= mem[rd_base +: PIXEL_WIDTH];
  end

endmodule

// File: rtl/integral_window_buffer.sv
// Streaming window-local integral image generator.
// Accepts raster-order pixels, keeps the last n rows, and for every complete
// n x n window emits its integral image tagged with the bottom-right (x,y).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   integral_window_buffer_if.slave (pixel and window handshakes)
//
// state   | meaning
// ACCEPT  | pixel_ready=1, write pixels, detect window-completing pixel
// COMPUTE | n+1 cycles: segment read for row k, accumulate row k one cycle later
// PRESENT | window_valid=1, outputs held until window_ready
module integral_window_buffer
  import integral_window_buffer_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 7,
  parameter int IMAGE_HEIGHT = 5,
  parameter int WINDOW_SIZE  = 4,
  parameter int PIXEL_WIDTH  = 1
) (
  input logic clk,
  input logic rst,
  integral_window_buffer_if.slave bus
);

  localparam int N   = WINDOW_SIZE;
  localparam int P   = PIXEL_WIDTH;
  localparam int WD  = clog2(IMAGE_WIDTH + 1);
  localparam int HD  = clog2(IMAGE_HEIGHT + 1);
  localparam int WDI = integral_width(N, P);
  localparam int SW  = clog2(N);
  localparam int CW  = clog2(N + 1);

  state_t          state;
  logic [WD-1:0]   col;
  logic [HD-1:0]   row;
  logic [SW-1:0]   row_slot;
  logic [SW-1:0]   rd_slot;
  logic [CW-1:0]   cnt;
  logic [N*P-1:0]  seg;
  logic            accept;
  logic            in_window;
  logic [WDI-1:0]  prefix [N];
  logic [WDI-1:0]  elem [N*N];

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(N - 1)) ? '0 : s + 1'b1;
  endfunction

  assign accept    = bus.pixel_valid & bus.pixel_ready;
  assign in_window = (col >= WD'(N - 1)) && (row >= HD'(N - 1));

  integral_line_store #(
    .N(N), .IMAGE_WIDTH(IMAGE_WIDTH), .PIXEL_WIDTH(P), .SW(SW), .WD(WD)
  ) u_line_store (
    .clk     (clk),
    .wr_en   (accept),
    .wr_slot (row_slot),
    .wr_col  (col),
    .wr_data (bus.pixel_data),
    .rd_slot (rd_slot),
    .rd_col  (bus.window_x - WD'(N - 1)),
    .seg     (seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ACCEPT;
      col              <= '0;
      row              <= '0;
      row_slot         <= '0;
      rd_slot          <= '0;
      cnt              <= '0;
      bus.pixel_ready  <= 1'b0;
      bus.window_valid <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.window_x     <= '0;
      bus.window_y     <= '0;
    end else begin
      case (state)
        ACCEPT: begin
          bus.frame_done  <= 1'b0;
          bus.pixel_ready <= 1'b1;
          if (accept) begin
            if (col == WD'(IMAGE_WIDTH - 1)) begin
              col <= '0;
              if (row == HD'(IMAGE_HEIGHT - 1)) begin
                row      <= '0;
                row_slot <= '0;
              end else begin
                row      <= row + 1'b1;
                row_slot <= slot_inc(row_slot);
              end
            end else begin
              col <= col + 1'b1;
            end
            if (in_window) begin
              bus.window_x    <= col;
              bus.window_y    <= row;
              // Oldest window row lives in the slot after the current one.
              rd_slot         <= slot_inc(row_slot);
              cnt             <= '0;
              bus.pixel_ready <= 1'b0;
              state           <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          rd_slot <= slot_inc(rd_slot);
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(N)) begin
            bus.window_valid <= 1'b1;
            state            <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.window_ready) begin
            bus.window_valid <= 1'b0;
            bus.pixel_ready  <= 1'b1;
            bus.frame_done   <= (bus.window_x == WD'(IMAGE_WIDTH - 1)) &&
                                (bus.window_y == HD'(IMAGE_HEIGHT - 1));
            state            <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  // Running row prefix sum over the segment read in the previous cycle.
  for (genvar c = 0; c < N; c++) begin : g_prefix
    if (c == 0) begin : g_first
      assign prefix[c] = WDI'(seg[P-1:0]);
    end else begin : g_next
      assign prefix[c] = prefix[c-1] + WDI'(seg[c*P +: P]);
    end
  end

  // Row r is accumulated when cnt==r+1, since the segment register lags the read by one cycle.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int IDX = elem_idx(r, c, N);
      logic [WDI-1:0] above;
      if (r == 0) begin : g_top
        assign above = '0;
      end else begin : g_below
        assign above = elem[IDX-N];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          elem[IDX] <= '0;
        else if (state == COMPUTE && cnt == CW'(r + 1))
          elem[IDX] <= above + prefix[c];
      end
      assign bus.integral_packed[IDX*WDI +: WDI] = elem[IDX];
    end
  end

endmodule

// File: tb/tb_integral_window_buffer.sv
module tb_integral_window_buffer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Selected DUT and its geometry for the reference model.
  int sel = 0;
  int W = 7, H = 5, P = 1, WDI = 5;
  int pix [16][16];

  logic       pv = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] pd = 8'd0;

  integral_window_buffer_if #(.IMAGE_WIDTH(7), .IMAGE_HEIGHT(5), .WINDOW_SIZE(4), .PIXEL_WIDTH(1)) bus_a ();
  integral_window_buffer_if #(.IMAGE_WIDTH(7), .IMAGE_HEIGHT(5), .WINDOW_SIZE(4), .PIXEL_WIDTH(8)) bus_b ();
  integral_window_buffer_if #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(6), .WINDOW_SIZE(4), .PIXEL_WIDTH(1)) bus_c ();

  integral_window_buffer #(.IMAGE_WIDTH(7), .IMAGE_HEIGHT(5), .WINDOW_SIZE(4), .PIXEL_WIDTH(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  integral_window_buffer #(.IMAGE_WIDTH(7), .IMAGE_HEIGHT(5), .WINDOW_SIZE(4), .PIXEL_WIDTH(8))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  integral_window_buffer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(6), .WINDOW_SIZE(4), .PIXEL_WIDTH(1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_a.pixel_valid  = pv && (sel == 0);
  assign bus_a.pixel_data   = pd[0];
  assign bus_a.window_ready = wr && (sel == 0);
  assign bus_b.pixel_valid  = pv && (sel == 1);
  assign bus_b.pixel_data   = pd;
  assign bus_b.window_ready = wr && (sel == 1);
  assign bus_c.pixel_valid  = pv && (sel == 2);
  assign bus_c.pixel_data   = pd[0];
  assign bus_c.window_ready = wr && (sel == 2);

  logic         o_pr, o_wv, o_fd;
  logic [2:0]   o_x, o_y;
  logic [191:0] o_pk;

  always_comb begin
    o_pr = bus_a.pixel_ready;  o_wv = bus_a.window_valid; o_fd = bus_a.frame_done;
    o_x  = bus_a.window_x;     o_y  = bus_a.window_y;     o_pk = 192'(bus_a.integral_packed);
    case (sel)
      1: begin
        o_pr = bus_b.pixel_ready;  o_wv = bus_b.window_valid; o_fd = bus_b.frame_done;
        o_x  = bus_b.window_x;     o_y  = bus_b.window_y;     o_pk = bus_b.integral_packed;
      end
      2: begin
        o_pr = bus_c.pixel_ready;  o_wv = bus_c.window_valid; o_fd = bus_c.frame_done;
        o_x  = bus_c.window_x;     o_y  = bus_c.window_y;     o_pk = 192'(bus_c.integral_packed);
      end
      default: ;
    endcase
  end

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window integral straight from the definition: element (r,c) is the sum
  // of all window pixels at or above row r and at or left of column c.
  function automatic logic [191:0] expected_window(input int x, input int y);
    logic [191:0] e = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int s = 0;
        for (int i = 0; i <= r; i++)
          for (int j = 0; j <= c; j++)
            s += pix[y-N+1+i][x-N+1+j];
        e |= 192'(s) << ((r * N + c) * WDI);
      end
    return e;
  endfunction

  task automatic set_cfg(input int s, input int w, input int h, input int p);
    sel = s; W = w; H = h; P = p;
    WDI = $clog2(N * N * ((1 << p) - 1) + 1);
  endtask

  // pattern: 0 all max, 1 single 1 at (0,0), 2 random.
  // ready_mode: 0 always ready, 1 random ready. stall_len: ready low at first window.
  // abort: assert reset during COMPUTE of the second window and return.
  task automatic run_frame(input int pattern, input int ready_mode, input int stall_len, input bit abort);
    int pi = 0, wi = 0, it = 0, acc_it = -100, stall = 0, fd_seen = 0;
    int total, wpr;
    bit prev_wv = 0, prev_wr = 0;
    logic [2:0]   prev_x = '0, prev_y = '0;
    logic [191:0] prev_pk = '0;
    wpr   = W - N + 1;
    total = wpr * (H - N + 1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix[y][x] = (pattern == 0) ? (1 << P) - 1 :
                    (pattern == 1) ? int'(x == 0 && y == 0) :
                    int'($urandom_range(0, (1 << P) - 1));
    while (wi < total && it < 2000) begin
      @(negedge clk);
      it++;
      if (abort && wi == 1 && it == acc_it + 2) begin
        rst = 1'b1;
        #1;
        check_vec("reset_mid_compute", 256'({o_pr, o_wv, o_fd, o_x, o_y, o_pk}), '0);
        @(negedge clk);
        check_vec("reset_held", 256'({o_pr, o_wv, o_fd, o_x, o_y, o_pk}), '0);
        rst = 1'b0;
        pv  = 1'b0;
        return;
      end
      if (o_wv && prev_wv && !prev_wr) begin
        check_vec("hold_outputs", 256'({o_x, o_y, o_pk}), 256'({prev_x, prev_y, prev_pk}));
        check_int("hold_pixel_ready", int'(o_pr), 0);
      end
      if (o_wv && !prev_wv) check_int("latency", it - acc_it, N + 2);
      if (o_fd) fd_seen++;
      if (o_wv && stall < stall_len) begin
        wr = 1'b0;
        stall++;
      end else begin
        wr = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      pv = (pi < W * H);
      if (pv) pd = 8'(pix[pi / W][pi % W]);
      #1;
      if (pv && o_pr) begin
        if ((pi % W) >= N - 1 && (pi / W) >= N - 1) acc_it = it;
        pi++;
      end
      if (o_wv && wr) begin
        check_vec("window_xy", 256'({o_x, o_y}), 256'({3'(N - 1 + wi % wpr), 3'(N - 1 + wi / wpr)}));
        check_vec("window_data", 256'(o_pk), 256'(expected_window(N - 1 + wi % wpr, N - 1 + wi / wpr)));
        wi++;
      end
      prev_wv = o_wv;
      prev_wr = wr;
      prev_x  = o_x;
      prev_y  = o_y;
      prev_pk = o_pk;
    end
    check_int("window_count", wi, total);
    check_int("pixel_count", pi, W * H);
    check_int("no_early_frame_done", fd_seen, 0);
    @(negedge clk);
    #1;
    check_int("frame_done_pulse", int'(o_fd), 1);
    check_int("valid_dropped", int'(o_wv), 0);
    check_int("ready_after_frame", int'(o_pr), 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_vec("reset_state", 256'({o_pr, o_wv, o_fd, o_x, o_y, o_pk}), '0);
    end
    @(negedge clk);
    rst = 1'b0;

    set_cfg(0, 7, 5, 1);
    run_frame(0, 0, 0, 1'b0);
    run_frame(1, 0, 0, 1'b0);
    run_frame(2, 0, 10, 1'b0);
    run_frame(2, 1, 0, 1'b0);
    run_frame(0, 0, 0, 1'b1);
    run_frame(0, 0, 0, 1'b0);

    set_cfg(1, 7, 5, 8);
    run_frame(0, 0, 0, 1'b0);
    run_frame(2, 1, 3, 1'b0);

    set_cfg(2, 4, 6, 1);
    run_frame(2, 1, 0, 1'b0);
    run_frame(0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
